// File: rtl/debug_uart_pkg.sv
// Shared constants and state encodings for the MOPS-Hub debug UART.
package debug_uart_pkg;

    // 10 MHz clock / 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 87;

    // 8N1 frame shape
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned STOP_BITS  = 1;
    localparam int unsigned FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

    // Bit-period counter width; caps CLKS_PER_BIT at 255
    localparam int unsigned COUNT_W = 8;
    localparam int unsigned INDEX_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        TX_IDLE      = 3'd0,
        TX_START_BIT = 3'd1,
        TX_DATA_BITS = 3'd2,
        TX_STOP_BIT  = 3'd3,
        TX_CLEANUP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START_BIT = 3'd1,
        RX_DATA_BITS = 3'd2,
        RX_STOP_BIT  = 3'd3,
        RX_CLEANUP   = 3'd4,
        RX_BREAK     = 3'd5
    } rx_state_e;

    // Counter value at the middle of a bit period
    function automatic int unsigned half_bit(input int unsigned clks);
        return (clks - 1) / 2;
    endfunction

endpackage

// File: rtl/debug_uart_sync.sv
// Two-flop synchronizer for asynchronous debug inputs.
module debug_uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Async,
    output logic o_Sync
);

    logic meta;

    // Resolve metastability over two stages; reset to the line's idle level
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            meta   <= RESET_VAL;
            o_Sync <= RESET_VAL;
        end else begin
            meta   <= i_Async;
            o_Sync <= meta;
        end
    end

endmodule

// File: rtl/debug_uart_receiver.sv
// 8N1 UART receiver for the debug port: mid-bit sampling, framing-error
// strobe, and break hold-off so a stuck-low line is not read as new frames.
module debug_uart_receiver
    import debug_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic         i_Clock,
    input  logic         i_Rst_n,
    input  logic         i_Rx_Serial,
    output logic         o_Rx_DV,
    output logic [7:0]   o_Rx_Byte,
    output logic         o_Rx_Active,
    output logic         o_Rx_Frame_Err
);

    localparam logic [COUNT_W-1:0] HALF_CNT = COUNT_W'(half_bit(CLKS_PER_BIT));
    localparam logic [COUNT_W-1:0] LAST_CNT = COUNT_W'(CLKS_PER_BIT - 1);
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [INDEX_W-1:0]   index_q, index_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [7:0]           byte_d;
    logic                 dv_d;
    logic                 err_d;
    logic                 active_d;

    debug_uart_sync #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_Async (i_Rx_Serial),
        .o_Sync  (rx_s)
    );

    // Next-state and next-output logic for the receive FSM
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        index_d  = index_q;
        shift_d  = shift_q;
        byte_d   = o_Rx_Byte;
        dv_d     = 1'b0;
        err_d    = 1'b0;
        active_d = o_Rx_Active;

        case (state_q)
            RX_IDLE: begin
                count_d = '0;
                index_d = '0;
                if (!rx_s) begin
                    // The detecting cycle already counts as the first start-bit cycle
                    state_d  = RX_START_BIT;
                    active_d = 1'b1;
                    count_d  = COUNT_W'(1);
                end
            end

            RX_START_BIT: begin
                if (count_q == HALF_CNT) begin
                    count_d = '0;
                    if (!rx_s) begin
                        state_d = RX_DATA_BITS;
                    end else begin
                        state_d  = RX_IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    count_d = count_q + COUNT_W'(1);
                end
            end

            RX_DATA_BITS: begin
                if (count_q == LAST_CNT) begin
                    count_d          = '0;
                    shift_d[index_q] = rx_s;
                    if (index_q != LAST_IDX) begin
                        index_d = index_q + INDEX_W'(1);
                    end else begin
                        index_d = '0;
                        state_d = RX_STOP_BIT;
                    end
                end else begin
                    count_d = count_q + COUNT_W'(1);
                end
            end

            RX_STOP_BIT: begin
                if (count_q == LAST_CNT) begin
                    count_d = '0;
                    if (rx_s) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = RX_CLEANUP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RX_BREAK;
                    end
                end else begin
                    count_d = count_q + COUNT_W'(1);
                end
            end

            RX_CLEANUP: begin
                active_d = 1'b0;
                state_d  = RX_IDLE;
            end

            RX_BREAK: begin
                if (rx_s) begin
                    state_d = RX_CLEANUP;
                end
            end

            default: begin
                state_d  = RX_IDLE;
                count_d  = '0;
                index_d  = '0;
                active_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q        <= RX_IDLE;
            count_q        <= '0;
            index_q        <= '0;
            shift_q        <= '0;
            o_Rx_Byte      <= 8'h00;
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
            o_Rx_Active    <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            index_q        <= index_d;
            shift_q        <= shift_d;
            o_Rx_Byte      <= byte_d;
            o_Rx_DV        <= dv_d;
            o_Rx_Frame_Err <= err_d;
            o_Rx_Active    <= active_d;
        end
    end

endmodule
